// File: rtl/circ_buf_ctrl.sv
// Pointer and occupancy controller for a K-in / J-out circular buffer.
// Generates the write strobe and base addresses; data words never pass through here.
module circ_buf_ctrl #(
  parameter int SIZE = 16,
  parameter int K    = 4,
  parameter int J    = 4,
  parameter int BIT  = $clog2(SIZE),
  parameter int CNT  = $clog2(SIZE + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           ld,
  output logic [BIT-1:0] write_add,
  output logic [BIT-1:0] read_add,
  output logic [CNT-1:0] count,
  output logic           full,
  output logic           empty
);

  localparam logic [CNT-1:0] LP_IN_MAX   = CNT'(SIZE - K);
  localparam logic [CNT-1:0] LP_J        = CNT'(J);
  localparam logic [CNT-1:0] LP_SIZE     = CNT'(SIZE);
  localparam logic [CNT:0]   LP_K_EXT    = (CNT + 1)'(K);
  localparam logic [CNT:0]   LP_J_EXT    = (CNT + 1)'(J);
  localparam logic [CNT:0]   LP_SIZE_EXT = (CNT + 1)'(SIZE);
  localparam logic [BIT-1:0] LP_K_PTR    = BIT'(K);
  localparam logic [BIT-1:0] LP_J_PTR    = BIT'(J);

  logic [BIT-1:0] r_wr_ptr;
  logic [BIT-1:0] r_rd_ptr;
  logic [CNT-1:0] r_count;
  logic           w_push;
  logic           w_pop;
  logic [CNT:0]   w_count_next;

  // Handshakes: a transfer fires on a cycle where valid && ready are both high.
  // in_ready/out_valid depend only on registered state and flush, so there is
  // no combinational path from out_ready to in_ready or from in_valid to out_valid.
  assign in_ready  = (r_count <= LP_IN_MAX) && !flush;
  assign out_valid = (r_count >= LP_J) && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign ld        = w_push;
  assign write_add = r_wr_ptr;
  assign read_add  = r_rd_ptr;
  assign count     = r_count;
  assign full      = (r_count == LP_SIZE);
  assign empty     = (r_count == '0);

  always_comb begin
    w_count_next = {1'b0, r_count};
    if (w_push) w_count_next = w_count_next + LP_K_EXT;
    if (w_pop)  w_count_next = w_count_next - LP_J_EXT;
  end

  // Pointers wrap modulo SIZE through BIT-bit truncation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      assert (w_count_next <= LP_SIZE_EXT);
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_K_PTR;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_J_PTR;
      r_count <= w_count_next[CNT-1:0];
    end
  end

endmodule

// File: tb/tb_circ_buf_ctrl.sv
// Bench for circ_buf_ctrl: three configurations (J = 4, 2, 1) share stimulus and
// are each checked against an arithmetic occupancy model, plus directed vectors.
module tb_circ_buf_ctrl;

  localparam int NDUT = 3;
  localparam int SZ   = 16;
  localparam int KA [NDUT] = '{4, 4, 4};
  localparam int JA [NDUT] = '{4, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       ir  [NDUT];
  logic       ov  [NDUT];
  logic       ldv [NDUT];
  logic [3:0] wa  [NDUT];
  logic [3:0] ra  [NDUT];
  logic [4:0] cnt [NDUT];
  logic       fl  [NDUT];
  logic       em  [NDUT];

  int m_cnt [NDUT];
  int m_wr  [NDUT];
  int m_rd  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  circ_buf_ctrl #(.SIZE(16), .K(4), .J(4)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .ld(ldv[0]), .write_add(wa[0]),
    .read_add(ra[0]), .count(cnt[0]), .full(fl[0]), .empty(em[0]));

  circ_buf_ctrl #(.SIZE(16), .K(4), .J(2)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .ld(ldv[1]), .write_add(wa[1]),
    .read_add(ra[1]), .count(cnt[1]), .full(fl[1]), .empty(em[1]));

  circ_buf_ctrl #(.SIZE(16), .K(4), .J(1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .ld(ldv[2]), .write_add(wa[2]),
    .read_add(ra[2]), .count(cnt[2]), .full(fl[2]), .empty(em[2]));

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic       ld;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pack_act(input int d);
    return {ir[d], ov[d], ldv[d], wa[d], ra[d], cnt[d], fl[d], em[d]};
  endfunction

  // Model: occupancy in words; a push needs room for K, a pop needs J present.
  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      logic e_ir, e_ov, e_ld;
      logic [17:0] exp_v;
      e_ir  = !flush && (m_cnt[d] + KA[d] <= SZ);
      e_ov  = !flush && (m_cnt[d] >= JA[d]);
      e_ld  = in_valid && e_ir;
      exp_v = {e_ir, e_ov, e_ld, 4'(m_wr[d]), 4'(m_rd[d]), 5'(m_cnt[d]),
               (m_cnt[d] == SZ), (m_cnt[d] == 0)};
      chk($sformatf("model_dut%0d", d), int'(pack_act(d)), int'(exp_v));
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < NDUT; d++) begin
      bit push, pop;
      if (rst || flush) begin
        m_cnt[d] = 0;
        m_wr[d]  = 0;
        m_rd[d]  = 0;
      end else begin
        push = in_valid && (m_cnt[d] + KA[d] <= SZ);
        pop  = out_ready && (m_cnt[d] >= JA[d]);
        if (push) begin
          m_wr[d]  = (m_wr[d] + KA[d]) % SZ;
          m_cnt[d] = m_cnt[d] + KA[d];
        end
        if (pop) begin
          m_rd[d]  = (m_rd[d] + JA[d]) % SZ;
          m_cnt[d] = m_cnt[d] - JA[d];
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic f, input logic iv, input logic ordy);
    rst = r;
    flush = f;
    in_valid = iv;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      m_cnt[d] = 0;
      m_wr[d]  = 0;
      m_rd[d]  = 0;
    end
  endtask

  task automatic run_cycles(input int n, input logic iv, input logic ordy);
    set_in(1'b0, 1'b0, iv, ordy);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    //         rst flush iv ordy  ir ov ld  wa     ra     cnt    full empty
    tbl[0]  = '{0, 0, 0, 0,  1, 0, 0, 4'd0,  4'd0,  5'd0,  0, 1};
    tbl[1]  = '{0, 0, 1, 0,  1, 0, 1, 4'd0,  4'd0,  5'd0,  0, 1};
    tbl[2]  = '{0, 0, 1, 0,  1, 1, 1, 4'd4,  4'd0,  5'd4,  0, 0};
    tbl[3]  = '{0, 0, 1, 0,  1, 1, 1, 4'd8,  4'd0,  5'd8,  0, 0};
    tbl[4]  = '{0, 0, 1, 0,  1, 1, 1, 4'd12, 4'd0,  5'd12, 0, 0};
    tbl[5]  = '{0, 0, 1, 0,  0, 1, 0, 4'd0,  4'd0,  5'd16, 1, 0};
    tbl[6]  = '{0, 0, 1, 0,  0, 1, 0, 4'd0,  4'd0,  5'd16, 1, 0};
    tbl[7]  = '{0, 0, 0, 1,  0, 1, 0, 4'd0,  4'd0,  5'd16, 1, 0};
    tbl[8]  = '{0, 0, 1, 1,  1, 1, 1, 4'd0,  4'd4,  5'd12, 0, 0};
    tbl[9]  = '{0, 0, 1, 1,  1, 1, 1, 4'd4,  4'd8,  5'd12, 0, 0};
    tbl[10] = '{0, 0, 0, 1,  1, 1, 0, 4'd8,  4'd12, 5'd12, 0, 0};
    tbl[11] = '{0, 1, 1, 1,  0, 0, 0, 4'd8,  4'd0,  5'd8,  0, 0};
    tbl[12] = '{0, 0, 0, 0,  1, 0, 0, 4'd0,  4'd0,  5'd0,  0, 1};

    // Reset, fill to full, drain with wrap, flush at count 8 (16/4/4).
    do_reset();
    for (int i = 0; i < 13; i++) begin
      logic [17:0] exp_v;
      set_in(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy);
      sample();
      exp_v = {tbl[i].ir, tbl[i].ov, tbl[i].ld, tbl[i].wa, tbl[i].ra, tbl[i].cnt,
               tbl[i].full, tbl[i].empty};
      chk($sformatf("vec%0d", i), int'(pack_act(0)), int'(exp_v));
      advance();
    end

    // Same clear with rst instead of flush.
    do_reset();
    run_cycles(2, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    sample();
    chk("rst_pre_cnt", int'(cnt[0]), 8);
    advance();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("rst_clr_cnt", int'(cnt[0]), 0);
    chk("rst_clr_ptrs", int'({wa[0], ra[0]}), 0);
    advance();

    // Steady state push+pop at count 8: count holds, pointers wrap.
    do_reset();
    run_cycles(2, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      sample();
      chk($sformatf("steady_cnt%0d", i), int'(cnt[0]), 8);
      chk($sformatf("steady_ld%0d", i), int'(ldv[0]), 1);
      chk($sformatf("steady_wa%0d", i), int'(wa[0]), (8 + 4 * i) % SZ);
      chk($sformatf("steady_ra%0d", i), int'(ra[0]), (4 * i) % SZ);
      advance();
    end

    // Drain with wrap on the J=2 instance.
    do_reset();
    run_cycles(4, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      sample();
      chk($sformatf("j2_ra%0d", i), int'(ra[1]), 2 * i);
      chk($sformatf("j2_ov%0d", i), int'(ov[1]), 1);
      advance();
    end
    sample();
    chk("j2_drained", int'({em[1], ov[1], cnt[1]}), 32'h40);
    advance();

    // Boundary stall on the J=1 instance at count 13.
    do_reset();
    run_cycles(4, 1'b1, 1'b0);
    run_cycles(3, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b1, 1'b1);
    sample();
    chk("j1_stall_cnt", int'(cnt[2]), 13);
    chk("j1_stall_ld", int'({ir[2], ldv[2], ov[2]}), 1);
    advance();
    sample();
    chk("j1_after_cnt", int'(cnt[2]), 12);
    chk("j1_after_ld", int'(ldv[2]), 1);
    advance();

    // Random traffic on all three configurations.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      sample();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/circ_buf_ctrl.md
Name: circ_buf_ctrl

Overview:
- Pointer/occupancy controller for the K-in / J-out circular buffer datapath.
- Accepts K-word bursts from upstream with a valid/ready handshake and presents J-word windows downstream with a valid/ready handshake.
- Drives the buffer's ld, write_add and read_add, and tracks occupancy so the buffer never overflows or underflows.
- Sits directly upstream of the buffer. Data words do not pass through this block; only control passes through it.

Parameters:
- SIZE, 16, number of WIDTH-bit entries in the buffer. Must be a power of two, >= 2.
- K, 4, words written per accepted push. 1 <= K <= SIZE.
- J, 4, words consumed per accepted pop. 1 <= J <= SIZE.
- BIT, $clog2(SIZE), address width.
- CNT, $clog2(SIZE+1), occupancy counter width.

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- rst, input, 1, synchronous, active-high reset.
- flush, input, 1, synchronous clear of pointers and occupancy.
- in_valid, input, 1, upstream has K words on the buffer's par_in.
- in_ready, output, 1, controller can accept a K-word push this cycle.
- out_valid, output, 1, J words are available at the buffer's par_out.
- out_ready, input, 1, downstream consumes the J-word window this cycle.
- ld, output, 1, write strobe to the buffer.
- write_add, output, BIT, base address for the K-word write.
- read_add, output, BIT, base address for the J-word read.
- count, output, CNT, current occupancy in words.
- full, output, 1, count == SIZE.
- empty, output, 1, count == 0.

Behaviour:
- State registers: wr_ptr[BIT], rd_ptr[BIT], count[CNT]. Nothing else is registered.
- Reset: when rst=1 at a clk edge, wr_ptr=0, rd_ptr=0, count=0. After reset: in_ready=1 (K<=SIZE), out_valid=0, ld=0 (with in_valid=0), full=0, empty=1, write_add=0, read_add=0.
- Priority order: rst > flush > push/pop. Flush zeroes wr_ptr, rd_ptr and count in the same edge as rst would. A push or pop asserted in a flush cycle is discarded and has no effect.
- Combinational outputs, from registered state only. There is no bypass from the same-cycle pop.
  - in_ready = (count <= SIZE-K) && !flush
  - out_valid = (count >= J) && !flush
  - write_add = wr_ptr
  - read_add = rd_ptr
  - full = (count == SIZE)
  - empty = (count == 0)
- Fire conditions:
  - push = in_valid && in_ready
  - pop = out_valid && out_ready
  - ld = push (combinational, same cycle). The buffer latches par_in at write_add..write_add+K-1 on that edge.
- Pointer update on the edge, modulo SIZE by BIT-bit truncation:
  - push: wr_ptr <= wr_ptr + K
  - pop: rd_ptr <= rd_ptr + J
- Count update on the edge:
  - push only: count <= count + K
  - pop only: count <= count - J
  - both: count <= count + K - J
  - neither: hold
  - Compute in CNT+1 bits. Result is always within 0..SIZE by construction.
- Simultaneous push and pop are both legal in one cycle. in_ready is judged on pre-pop count, so a full-minus-less-than-K buffer stalls the push even if a pop fires in the same cycle. This is intentional to avoid a combinational path from out_ready to in_ready.
- Data latency: a word written on edge N is visible through read_add no earlier than the cycle after edge N. out_valid rises the cycle after the push that makes count >= J.
- Wrap-around: a write or read window may straddle SIZE-1 -> 0. The buffer's address generator handles the straddle; the controller only supplies the base address.
- Handshake rules:
  - Upstream must hold in_valid and data until in_ready.
  - The controller never deasserts out_valid without a pop, except on flush or rst.
  - in_ready may toggle freely.
- Assertions for the bench:
  - count never exceeds SIZE.
  - count never goes negative (no underflow).
  - (wr_ptr - rd_ptr) mod SIZE == count mod SIZE.

Test Plan:
1. Reset then idle, with defaults (16/4/4): rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, empty=1, count=0, write_add=0, read_add=0.
2. Fill to full: in_valid=1 for 4 cycles, out_ready=0 -> ld pulses 4 times at write_add 0, 4, 8, 12. After the 4th push, count=16, full=1, in_ready=0, wr_ptr wraps to 0. A 5th in_valid is not accepted.
3. Drain with wrap, J=2 variant (K=4): push 4 times, then out_ready=1 -> 8 pops at read_add 0, 2, ..., 14. count falls 16->0. empty=1 and out_valid=0 after the 8th pop.
4. Simultaneous push/pop at steady state: count=8, in_valid=1, out_ready=1 for 10 cycles -> count stays 8, both pointers advance 4 per cycle and wrap 12->0, ld=1 every cycle.
5. Boundary stall: count=13 (K=4, J=1 variant) with in_valid=1 and out_ready=1 -> that cycle only the pop fires, count becomes 12. The next cycle the push is accepted.
6. Mid-operation clear: at count=8 assert flush with in_valid=1 -> ld=0 that cycle, then count=0, pointers=0. Repeat the sequence with rst in place of flush -> same result.
